// File: rtl/bsg_dmc_pearl_pkg.sv
// Shared types and default widths for the DMC pearl tag boot sequencer.
package bsg_dmc_pearl_pkg;

  localparam int unsigned bsg_dmc_pearl_tag_local_els_gp         = 32;
  localparam int unsigned bsg_dmc_pearl_tag_max_payload_width_gp = 16;
  localparam int unsigned bsg_dmc_pearl_tag_lg_els_gp = $clog2(bsg_dmc_pearl_tag_local_els_gp);
  localparam int unsigned bsg_dmc_pearl_tag_lg_len_gp = $clog2(bsg_dmc_pearl_tag_max_payload_width_gp + 1);

  // One table entry at the default widths
  typedef struct packed {
    logic [bsg_dmc_pearl_tag_lg_els_gp-1:0]            node_id;
    logic                                              data_not_reset;
    logic [bsg_dmc_pearl_tag_lg_len_gp-1:0]            len;
    logic [bsg_dmc_pearl_tag_max_payload_width_gp-1:0] payload;
  } bsg_dmc_pearl_tag_seq_entry_s;

  typedef enum logic [3:0] {
    e_seq_idle,
    e_seq_prefill,
    e_seq_start,
    e_seq_node,
    e_seq_dnr,
    e_seq_len,
    e_seq_payload,
    e_seq_gap,
    e_seq_done
  } bsg_dmc_pearl_tag_seq_state_e;

endpackage

// File: rtl/bsg_dmc_pearl_tag_seq_if.sv
// Control, entry-table and tag-stream signals between boot logic and the tag sequencer.
interface bsg_dmc_pearl_tag_seq_if
  import bsg_dmc_pearl_pkg::*;
#(
  parameter int unsigned els_p               = bsg_dmc_pearl_tag_local_els_gp,
  parameter int unsigned max_payload_width_p = bsg_dmc_pearl_tag_max_payload_width_gp,
  parameter int unsigned num_entries_p       = 32
) ();

  localparam int unsigned lg_els = $clog2(els_p);
  localparam int unsigned lg_len = $clog2(max_payload_width_p + 1);
  localparam int unsigned addr_w = $clog2(num_entries_p);

  logic                           start_i;
  logic                           abort_i;
  logic [addr_w-1:0]              entry_addr_o;
  logic [lg_els-1:0]              entry_node_id_i;
  logic                           entry_data_not_reset_i;
  logic [lg_len-1:0]              entry_len_i;
  logic [max_payload_width_p-1:0] entry_payload_i;
  logic                           entry_last_i;
  logic                           tag_data_o;
  logic                           busy_o;
  logic                           done_o;
  logic                           aborted_o;

  modport master (
    output start_i, abort_i, entry_node_id_i, entry_data_not_reset_i,
           entry_len_i, entry_payload_i, entry_last_i,
    input  entry_addr_o, tag_data_o, busy_o, done_o, aborted_o
  );

  modport slave (
    input  start_i, abort_i, entry_node_id_i, entry_data_not_reset_i,
           entry_len_i, entry_payload_i, entry_last_i,
    output entry_addr_o, tag_data_o, busy_o, done_o, aborted_o
  );

endinterface

// File: rtl/bsg_dmc_pearl_tag_serializer.sv
// LSB-first shift register for the node/dnr/len/payload fields of one tag packet.
module bsg_dmc_pearl_tag_serializer #(
  parameter int unsigned width_p = 32,
  parameter int unsigned cnt_w_p = $clog2(width_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load,
  input  logic               shift,
  input  logic [width_p-1:0] data,
  input  logic [cnt_w_p-1:0] count,
  output logic               next_bit_c,
  output logic               last_c
);

  // sr_r holds the bits still to go after the one currently on the line
  logic [width_p-1:0] sr_r;
  logic [cnt_w_p-1:0] cnt_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sr_r  <= '0;
      cnt_r <= '0;
    end else if (load) begin
      sr_r  <= data >> 1;
      cnt_r <= count - cnt_w_p'(1);
    end else if (shift) begin
      sr_r <= sr_r >> 1;
      if (cnt_r != '0) cnt_r <= cnt_r - cnt_w_p'(1);
    end
  end

  assign next_bit_c = load ? data[0] : sr_r[0];
  assign last_c     = (cnt_r == '0);

endmodule

// File: rtl/bsg_dmc_pearl_tag_sequencer.sv
// Walks the entry table after start and serializes one bsg_tag packet per entry onto tag_data_o.
module bsg_dmc_pearl_tag_sequencer
  import bsg_dmc_pearl_pkg::*;
#(
  parameter int unsigned els_p               = bsg_dmc_pearl_tag_local_els_gp,
  parameter int unsigned max_payload_width_p = bsg_dmc_pearl_tag_max_payload_width_gp,
  parameter int unsigned num_entries_p       = 32,
  parameter int unsigned prefill_cycles_p    = 64,
  parameter int unsigned gap_cycles_p        = 4
) (
  input logic               clk_i,
  input logic               reset_n_i,
  bsg_dmc_pearl_tag_seq_if.slave seq
);

  localparam int unsigned lg_els    = $clog2(els_p);
  localparam int unsigned lg_len    = $clog2(max_payload_width_p + 1);
  localparam int unsigned addr_w    = $clog2(num_entries_p);
  localparam int unsigned ser_w     = max_payload_width_p + lg_len + 1 + lg_els;
  localparam int unsigned ser_cnt_w = $clog2(ser_w + 1);
  localparam int unsigned cnt_max_a = (prefill_cycles_p > gap_cycles_p) ? prefill_cycles_p : gap_cycles_p;
  localparam int unsigned cnt_max_b = (lg_els > lg_len) ? lg_els : lg_len;
  localparam int unsigned cnt_max   = (cnt_max_a > cnt_max_b) ? cnt_max_a : cnt_max_b;
  localparam int unsigned cnt_w     = $clog2(cnt_max + 1);

  bsg_dmc_pearl_tag_seq_state_e state_r, state_n;
  logic [cnt_w-1:0]  cnt_r, cnt_n;
  logic [addr_w-1:0] addr_r, addr_n;
  logic [lg_len-1:0] len_r, len_n, len_c;
  logic              last_r, last_n, abort_r, abort_n;
  logic              tag_r, tag_n, busy_r, busy_n, done_r, done_n, aborted_r, aborted_n;
  logic              ser_load, ser_shift, ser_bit_c, ser_last_c;
  logic [ser_w-1:0]     ser_data;
  logic [ser_cnt_w-1:0] ser_count;

  // Oversized lengths are clamped before both transmission and bit counting
  assign len_c     = (seq.entry_len_i > lg_len'(max_payload_width_p)) ? lg_len'(max_payload_width_p)
                                                                      : seq.entry_len_i;
  assign ser_data  = {seq.entry_payload_i, len_c, seq.entry_data_not_reset_i, seq.entry_node_id_i};
  assign ser_count = ser_cnt_w'(lg_els + 1 + lg_len) + ser_cnt_w'(len_c);

  bsg_dmc_pearl_tag_serializer #(
    .width_p (ser_w),
    .cnt_w_p (ser_cnt_w)
  ) serializer (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load       (ser_load),
    .shift      (ser_shift),
    .data       (ser_data),
    .count      (ser_count),
    .next_bit_c (ser_bit_c),
    .last_c     (ser_last_c)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r   <= e_seq_idle;
      cnt_r     <= '0;
      addr_r    <= '0;
      len_r     <= '0;
      last_r    <= 1'b0;
      abort_r   <= 1'b0;
      tag_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      addr_r    <= addr_n;
      len_r     <= len_n;
      last_r    <= last_n;
      abort_r   <= abort_n;
      tag_r     <= tag_n;
      busy_r    <= busy_n;
      done_r    <= done_n;
      aborted_r <= aborted_n;
    end
  end

  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    addr_n    = addr_r;
    len_n     = len_r;
    last_n    = last_r;
    abort_n   = abort_r | seq.abort_i;
    busy_n    = busy_r;
    done_n    = done_r;
    aborted_n = aborted_r;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    tag_n     = 1'b0;

    unique case (state_r)
      e_seq_idle, e_seq_done: begin
        abort_n = 1'b0;
        if (seq.start_i) begin
          state_n   = e_seq_prefill;
          cnt_n     = cnt_w'(prefill_cycles_p - 1);
          addr_n    = '0;
          busy_n    = 1'b1;
          done_n    = 1'b0;
          aborted_n = 1'b0;
        end
      end
      e_seq_prefill: begin
        if (cnt_r != '0) cnt_n = cnt_r - cnt_w'(1);
        else if (abort_n) begin
          state_n   = e_seq_idle;
          abort_n   = 1'b0;
          busy_n    = 1'b0;
          aborted_n = 1'b1;
        end else state_n = e_seq_start;
      end
      e_seq_start: begin
        ser_load = 1'b1;
        len_n    = len_c;
        last_n   = seq.entry_last_i;
        state_n  = e_seq_node;
        cnt_n    = cnt_w'(lg_els - 1);
      end
      e_seq_node: begin
        ser_shift = 1'b1;
        if (cnt_r != '0) cnt_n = cnt_r - cnt_w'(1);
        else state_n = e_seq_dnr;
      end
      e_seq_dnr: begin
        ser_shift = 1'b1;
        state_n   = e_seq_len;
        cnt_n     = cnt_w'(lg_len - 1);
      end
      e_seq_len: begin
        ser_shift = 1'b1;
        if (cnt_r != '0) cnt_n = cnt_r - cnt_w'(1);
        else if (len_r == '0) begin
          state_n = e_seq_gap;
          cnt_n   = cnt_w'(gap_cycles_p - 1);
        end else state_n = e_seq_payload;
      end
      e_seq_payload: begin
        ser_shift = 1'b1;
        if (ser_last_c) begin
          state_n = e_seq_gap;
          cnt_n   = cnt_w'(gap_cycles_p - 1);
        end
      end
      e_seq_gap: begin
        if (cnt_r != '0) cnt_n = cnt_r - cnt_w'(1);
        else if (abort_n) begin
          state_n   = e_seq_idle;
          abort_n   = 1'b0;
          busy_n    = 1'b0;
          aborted_n = 1'b1;
        end else if (last_r || addr_r == addr_w'(num_entries_p - 1)) begin
          state_n = e_seq_done;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          state_n = e_seq_start;
          addr_n  = addr_r + addr_w'(1);
        end
      end
      default: state_n = e_seq_idle;
    endcase

    // Line value for the upcoming cycle, so tag_data_o leaves a flop
    unique case (state_n)
      e_seq_start:                                     tag_n = 1'b1;
      e_seq_node, e_seq_dnr, e_seq_len, e_seq_payload: tag_n = ser_bit_c;
      default:                                         tag_n = 1'b0;
    endcase
  end

  assign seq.entry_addr_o = addr_r;
  assign seq.tag_data_o   = tag_r;
  assign seq.busy_o       = busy_r;
  assign seq.done_o       = done_r;
  assign seq.aborted_o    = aborted_r;

endmodule

// File: tb/tb_bsg_dmc_pearl_tag_sequencer.sv
// Bench for the tag sequencer: directed scenarios plus randomized tables against a stream model.
module tb_bsg_dmc_pearl_tag_sequencer;
  import bsg_dmc_pearl_pkg::*;

  localparam int unsigned els_p   = 8;
  localparam int unsigned max_pl  = 8;
  localparam int unsigned n_ent   = 4;
  localparam int unsigned prefill = 4;
  localparam int unsigned gap     = 2;
  localparam int unsigned lg_els  = 3;
  localparam int unsigned lg_len  = 4;

  logic clk;
  logic reset_n;

  bsg_dmc_pearl_tag_seq_if #(.els_p(els_p), .max_payload_width_p(max_pl), .num_entries_p(n_ent)) seq ();

  bsg_dmc_pearl_tag_sequencer #(
    .els_p               (els_p),
    .max_payload_width_p (max_pl),
    .num_entries_p       (n_ent),
    .prefill_cycles_p    (prefill),
    .gap_cycles_p        (gap)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .seq       (seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bsg_dmc_pearl_tag_seq_entry_s tbl [n_ent];
  bit                           tbl_last [n_ent];

  assign seq.entry_node_id_i        = 3'(tbl[seq.entry_addr_o].node_id);
  assign seq.entry_data_not_reset_i = tbl[seq.entry_addr_o].data_not_reset;
  assign seq.entry_len_i            = 4'(tbl[seq.entry_addr_o].len);
  assign seq.entry_payload_i        = 8'(tbl[seq.entry_addr_o].payload);
  assign seq.entry_last_i           = tbl_last[seq.entry_addr_o];

  int n_tests = 0;
  int n_fail  = 0;

  // Expected per-cycle line value, table index and field name from the first PREFILL cycle on
  bit    exp_bit  [$];
  int    exp_addr [$];
  string exp_fld  [$];
  bit    exp_done, exp_aborted;
  int    exp_final_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_entry(input int k, input int node, input bit dnr, input int len,
                           input int pl, input bit last);
    tbl[k].node_id        = 5'(node);
    tbl[k].data_not_reset = dnr;
    tbl[k].len            = 5'(len);
    tbl[k].payload        = 16'(pl);
    tbl_last[k]           = last;
  endtask

  task automatic push_bits(input int n, input int val, input int addr, input string fld);
    for (int i = 0; i < n; i++) begin
      exp_bit.push_back(val[i]);
      exp_addr.push_back(addr);
      exp_fld.push_back(fld);
    end
  endtask

  // abort_at = stream cycle during which abort_i is high (0 = none)
  task automatic build_exp(input int abort_at);
    exp_bit.delete();
    exp_addr.delete();
    exp_fld.delete();
    exp_done = 1'b0;
    exp_aborted = 1'b0;
    exp_final_addr = 0;
    push_bits(prefill, 0, 0, "prefill");
    if (abort_at > 0 && abort_at <= exp_bit.size()) begin
      exp_aborted = 1'b1;
      return;
    end
    for (int k = 0; k < n_ent; k++) begin
      int l;
      l = (int'(tbl[k].len) > max_pl) ? max_pl : int'(tbl[k].len);
      push_bits(1, 1, k, "start");
      push_bits(lg_els, int'(tbl[k].node_id), k, "node");
      push_bits(1, int'(tbl[k].data_not_reset), k, "dnr");
      push_bits(lg_len, l, k, "len");
      push_bits(l, int'(tbl[k].payload), k, "payload");
      push_bits(gap, 0, k, "gap");
      exp_final_addr = k;
      if (abort_at > 0 && abort_at <= exp_bit.size()) begin
        exp_aborted = 1'b1;
        break;
      end
      if (tbl_last[k] || k == n_ent - 1) begin
        exp_done = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, " tag"},     32'(seq.tag_data_o),   32'(0));
    check_eq({tag, " addr"},    32'(seq.entry_addr_o), 32'(0));
    check_eq({tag, " busy"},    32'(seq.busy_o),       32'(0));
    check_eq({tag, " done"},    32'(seq.done_o),       32'(0));
    check_eq({tag, " aborted"}, 32'(seq.aborted_o),    32'(0));
  endtask

  // Start a sequence and compare every cycle of the stream plus the end state
  task automatic run_seq(input string name, input int abort_at, input int busy_start_at,
                         input bit abort_with_start);
    build_exp(abort_at);
    @(negedge clk);
    seq.start_i = 1'b1;
    seq.abort_i = abort_with_start;
    for (int c = 1; c <= exp_bit.size(); c++) begin
      @(negedge clk);
      seq.start_i = (c == busy_start_at);
      seq.abort_i = (c == abort_at);
      check_eq($sformatf("%s %s c%0d", name, exp_fld[c-1], c), 32'(seq.tag_data_o), 32'(exp_bit[c-1]));
      check_eq($sformatf("%s addr c%0d", name, c), 32'(seq.entry_addr_o), 32'(exp_addr[c-1]));
      check_eq($sformatf("%s busy c%0d", name, c), 32'(seq.busy_o), 32'(1));
      check_eq($sformatf("%s done c%0d", name, c), 32'(seq.done_o), 32'(0));
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seq.start_i = 1'b0;
      seq.abort_i = 1'b0;
      check_eq($sformatf("%s end tag +%0d", name, c),     32'(seq.tag_data_o),   32'(0));
      check_eq($sformatf("%s end busy +%0d", name, c),    32'(seq.busy_o),       32'(0));
      check_eq($sformatf("%s end done +%0d", name, c),    32'(seq.done_o),       32'(exp_done));
      check_eq($sformatf("%s end aborted +%0d", name, c), 32'(seq.aborted_o),    32'(exp_aborted));
      check_eq($sformatf("%s end addr +%0d", name, c),    32'(seq.entry_addr_o), 32'(exp_final_addr));
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    seq.start_i = 1'b0;
    seq.abort_i = 1'b0;
    for (int k = 0; k < n_ent; k++) set_entry(k, 0, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // Single data packet
    set_entry(0, 5, 1'b1, 8, 'hA5, 1'b1);
    run_seq("single", 0, 0, 1'b0);

    // Three entries with a zero-length reset packet in the middle
    set_entry(0, 1, 1'b1, 3, 'h5, 1'b0);
    set_entry(1, 2, 1'b0, 0, 0, 1'b0);
    set_entry(2, 6, 1'b1, 5, 'h1B, 1'b1);
    run_seq("three", 0, 0, 1'b0);

    // Length clamp
    set_entry(0, 3, 1'b1, 12, 'h3C, 1'b1);
    run_seq("clamp", 0, 0, 1'b0);

    // Abort mid-payload of entry 0, and abort during prefill
    for (int k = 0; k < n_ent; k++) set_entry(k, k + 1, 1'b1, 8, 'h5A + k, 1'b0);
    run_seq("abort_payload", 16, 0, 1'b0);
    run_seq("abort_prefill", 2, 0, 1'b0);

    // Start while busy, and start+abort together
    set_entry(0, 5, 1'b1, 8, 'hA5, 1'b1);
    run_seq("busy_start", 0, 10, 1'b1);

    // Reset in the middle of the node field
    @(negedge clk);
    seq.start_i = 1'b1;
    for (int c = 1; c <= prefill + 2; c++) begin
      @(negedge clk);
      seq.start_i = 1'b0;
    end
    reset_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    reset_n = 1'b1;
    run_seq("after_reset", 0, 0, 1'b0);

    // No last flags: address wrap ends the sequence
    for (int k = 0; k < n_ent; k++) set_entry(k, 7 - k, k[0], k + 2, 'hC3 >> k, 1'b0);
    run_seq("wrap", 0, 0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      int ab, bs;
      for (int k = 0; k < n_ent; k++)
        set_entry(k, int'($urandom_range(7, 0)), 1'($urandom), int'($urandom_range(15, 0)),
                  int'($urandom_range(255, 0)), ($urandom_range(3, 0) == 0));
      ab = ($urandom_range(2, 0) == 0) ? int'($urandom_range(80, 1)) : 0;
      bs = ($urandom_range(2, 0) == 0) ? int'($urandom_range(20, 1)) : 0;
      run_seq($sformatf("rand%0d", it), ab, bs, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
